// File: rtl/servant_ram_pkg.sv
// Shared definitions for the two-port servant RAM: FSM states, grant encoding
// and the legal read-latency range.
package servant_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic GNT_IB = 1'b0;
  localparam logic GNT_DB = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    else if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    else return lat;
  endfunction

endpackage

// File: rtl/servant_ram_arb2.sv
// Two-requester arbiter (ib/db): fixed priority with db winning, or
// round-robin against the last granted port.
module servant_ram_arb2
  import servant_ram_pkg::*;
#(
  parameter int ARB_RR = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_ib,
  input  logic i_req_db,
  input  logic i_take,
  output logic o_gnt
);

  logic r_last;

  // Grant decision; only meaningful while at least one request is high.
  always_comb begin
    if (i_req_ib && i_req_db) begin
      if (ARB_RR != 0) o_gnt = (r_last == GNT_IB) ? GNT_DB : GNT_IB;
      else o_gnt = GNT_DB;
    end else if (i_req_db) begin
      o_gnt = GNT_DB;
    end else begin
      o_gnt = GNT_IB;
    end
  end

  // Remember who was served last so round-robin can alternate.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_last <= GNT_IB;
    else if (i_take) r_last <= o_gnt;
  end

endmodule

// File: rtl/servant_ram_arb.sv
// Word RAM shared by SERV ibus (read-only) and dbus through an internal arbiter.
// Optional out-of-range error reporting is enabled with `define SERVANT_RAM_ERR_EN.
module servant_ram_arb
  import servant_ram_pkg::*;
#(
  parameter int depth  = 256,
  parameter int aw     = $clog2(depth),
  parameter     memfile = "",
  parameter int RD_LAT = 1,
  parameter int ARB_RR = 0
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic [29:0] i_ib_adr,
  input  logic        i_ib_cyc,
  output logic [31:0] o_ib_rdt,
  output logic        o_ib_ack,
  output logic        o_ib_err,
  input  logic [29:0] i_db_adr,
  input  logic [31:0] i_db_dat,
  input  logic [3:0]  i_db_sel,
  input  logic        i_db_we,
  input  logic        i_db_cyc,
  output logic [31:0] o_db_rdt,
  output logic        o_db_ack,
  output logic        o_db_err
);

  localparam int LAT   = clamp_lat(RD_LAT);
  localparam int IW    = aw - 2;
  localparam int WORDS = depth / 4;
  localparam logic [1:0] CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  logic [31:0] r_mem [0:WORDS-1];

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_gnt;
  logic        r_oor;
  logic [31:0] r_rdata;
  logic        r_ib_ack, r_ib_err, r_db_ack, r_db_err;
  logic [31:0] r_ib_rdt, r_db_rdt;

  logic        w_any, w_gnt, w_take, w_oor, w_wr;
  logic        w_resp, w_resp_gnt, w_resp_oor, w_resp_cyc;
  logic [29:0] w_adr;
  logic [IW-1:0] w_idx;
  logic [31:0] w_rd_word, w_resp_dat;

  initial begin
    for (int i = 0; i < WORDS; i++) r_mem[i] = 32'h0;
  end

  servant_ram_arb2 #(.ARB_RR(ARB_RR)) u_arb (
    .i_clk    (i_wb_clk),
    .i_rst    (i_wb_rst),
    .i_req_ib (i_ib_cyc),
    .i_req_db (i_db_cyc),
    .i_take   (w_take),
    .o_gnt    (w_gnt)
  );

  assign w_any  = i_ib_cyc | i_db_cyc;
  assign w_take = (r_state == IDLE) && w_any && !i_wb_rst;
  assign w_adr  = (w_gnt == GNT_DB) ? i_db_adr : i_ib_adr;
  assign w_idx  = w_adr[IW-1:0];

`ifdef SERVANT_RAM_ERR_EN
  assign w_oor = |w_adr[29:IW];
`else
  logic [29-IW:0] w_unused_adr;
  assign w_unused_adr = w_adr[29:IW];
  assign w_oor = 1'b0;
`endif

  assign w_wr      = w_take && (w_gnt == GNT_DB) && i_db_we && !w_oor;
  assign w_rd_word = r_mem[w_idx];

  // With a one-cycle latency the response is produced on the grant edge itself,
  // so it has to come straight from the request rather than the latched copy.
  assign w_resp     = (w_take && (LAT == 1)) || ((r_state == WAIT) && (r_cnt == 2'd0));
  assign w_resp_gnt = (r_state == IDLE) ? w_gnt : r_gnt;
  assign w_resp_oor = (r_state == IDLE) ? w_oor : r_oor;
  assign w_resp_dat = (r_state == IDLE) ? w_rd_word : r_rdata;
  assign w_resp_cyc = (w_resp_gnt == GNT_DB) ? i_db_cyc : i_ib_cyc;

  // Byte-lane write commits on the grant edge; contents survive reset.
  always_ff @(posedge i_wb_clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_db_sel[b]) r_mem[w_idx][8*b +: 8] <= i_db_dat[8*b +: 8];
      end
    end
  end

  // Access FSM plus registered ack/err/rdt outputs.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_gnt    <= GNT_IB;
      r_oor    <= 1'b0;
      r_rdata  <= 32'h0;
      r_ib_ack <= 1'b0;
      r_ib_err <= 1'b0;
      r_db_ack <= 1'b0;
      r_db_err <= 1'b0;
      r_ib_rdt <= 32'h0;
      r_db_rdt <= 32'h0;
    end else begin
      r_ib_ack <= 1'b0;
      r_ib_err <= 1'b0;
      r_db_ack <= 1'b0;
      r_db_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_gnt   <= w_gnt;
            r_oor   <= w_oor;
            r_rdata <= w_rd_word;
            r_cnt   <= CNT_INIT;
            r_state <= (LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) r_state <= RESP;
          else r_cnt <= r_cnt - 2'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // A requester that already dropped cyc gets no pulse and keeps its old rdt.
      if (w_resp && w_resp_cyc) begin
        if (w_resp_oor) begin
          if (w_resp_gnt == GNT_DB) r_db_err <= 1'b1;
          else r_ib_err <= 1'b1;
        end else if (w_resp_gnt == GNT_DB) begin
          r_db_ack <= 1'b1;
          r_db_rdt <= w_resp_dat;
        end else begin
          r_ib_ack <= 1'b1;
          r_ib_rdt <= w_resp_dat;
        end
      end
    end
  end

  assign o_ib_ack = r_ib_ack;
  assign o_ib_err = r_ib_err;
  assign o_ib_rdt = r_ib_rdt;
  assign o_db_ack = r_db_ack;
  assign o_db_err = r_db_err;
  assign o_db_rdt = r_db_rdt;

endmodule

// File: tb/tb_servant_ram_arb.sv
// Bench for servant_ram_arb: two instances (RD_LAT=1 fixed, RD_LAT=3 round-robin),
// each with directed transfers, random traffic and a per-cycle reference model.
`timescale 1ns/1ps
module tb_servant_ram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SERVANT_RAM_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int RR  = (g == 0) ? 0 : 1;

    logic        rst;
    logic [29:0] ib_adr, db_adr;
    logic        ib_cyc, db_cyc, db_we;
    logic [31:0] db_dat;
    logic [3:0]  db_sel;
    logic [31:0] ib_rdt, db_rdt;
    logic        ib_ack, ib_err, db_ack, db_err;
    bit          fin = 1'b0;

    servant_ram_arb #(.depth(256), .RD_LAT(LAT), .ARB_RR(RR)) dut (
      .i_wb_clk (clk),
      .i_wb_rst (rst),
      .i_ib_adr (ib_adr),
      .i_ib_cyc (ib_cyc),
      .o_ib_rdt (ib_rdt),
      .o_ib_ack (ib_ack),
      .o_ib_err (ib_err),
      .i_db_adr (db_adr),
      .i_db_dat (db_dat),
      .i_db_sel (db_sel),
      .i_db_we  (db_we),
      .i_db_cyc (db_cyc),
      .o_db_rdt (db_rdt),
      .o_db_ack (db_ack),
      .o_db_err (db_err)
    );

    // Reference model: transaction-level view of grants, memory and response timing.
    logic [31:0] m_mem [0:63];
    bit          m_started = 1'b0;
    bit          m_have = 1'b0, m_last = 1'b0, m_port = 1'b0, m_oor = 1'b0;
    logic [31:0] m_data = 32'h0;
    int          m_cyc_n = 0, m_resp_at = 0, m_next_free = 0;
    logic        e_ib_ack = 1'b0, e_db_ack = 1'b0, e_ib_err = 1'b0, e_db_err = 1'b0;
    logic [31:0] e_ib_rdt = 32'h0, e_db_rdt = 32'h0;

    initial begin : model
      logic [29:0] a;
      for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
      forever begin
        @(posedge clk);
        if (rst) begin
          m_started = 1'b1; m_have = 1'b0; m_next_free = 0; m_last = 1'b0;
          e_ib_ack = 1'b0; e_db_ack = 1'b0; e_ib_err = 1'b0; e_db_err = 1'b0;
          e_ib_rdt = 32'h0; e_db_rdt = 32'h0;
        end else if (m_started) begin
          e_ib_ack = 1'b0; e_db_ack = 1'b0; e_ib_err = 1'b0; e_db_err = 1'b0;
          if (m_cyc_n >= m_next_free && (ib_cyc || db_cyc)) begin
            if (ib_cyc && db_cyc) m_port = (RR == 1) ? !m_last : 1'b1;
            else m_port = db_cyc;
            a = m_port ? db_adr : ib_adr;
            m_oor  = ERR_ON && (a[29:6] != 24'h0);
            m_data = m_mem[a[5:0]];
            if (m_port && db_we && !m_oor)
              for (int b = 0; b < 4; b++)
                if (db_sel[b]) m_mem[a[5:0]][8*b +: 8] = db_dat[8*b +: 8];
            m_resp_at   = m_cyc_n + LAT - 1;
            m_next_free = m_cyc_n + LAT + 1;
            m_have = 1'b1;
            m_last = m_port;
          end
          if (m_have && m_cyc_n == m_resp_at) begin
            m_have = 1'b0;
            if (m_port ? db_cyc : ib_cyc) begin
              if (m_oor && m_port) e_db_err = 1'b1;
              else if (m_oor) e_ib_err = 1'b1;
              else if (m_port) begin e_db_ack = 1'b1; e_db_rdt = m_data; end
              else begin e_ib_ack = 1'b1; e_ib_rdt = m_data; end
            end
          end
        end
        m_cyc_n++;
      end
    end

    initial begin : compare
      forever begin
        @(negedge clk);
        if (m_started) begin
          chk(g, "ib_ack", 32'(ib_ack), 32'(e_ib_ack));
          chk(g, "ib_err", 32'(ib_err), 32'(e_ib_err));
          chk(g, "ib_rdt", ib_rdt, e_ib_rdt);
          chk(g, "db_ack", 32'(db_ack), 32'(e_db_ack));
          chk(g, "db_err", 32'(db_err), 32'(e_db_err));
          chk(g, "db_rdt", db_rdt, e_db_rdt);
        end
      end
    end

    function automatic logic [29:0] rnd_adr();
      logic [29:0] a;
      a = 30'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a[20] = 1'b1;
      return a;
    endfunction

    // One transfer after an idle cycle; latency counts negedges from request to response.
    task automatic txn(input bit port, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit w,
                       output logic [31:0] rd, output bit e, output int lat);
      bit got;
      got = 1'b0; rd = 32'h0; e = 1'b0; lat = 0;
      @(negedge clk);
      if (port) begin db_adr = a; db_dat = d; db_sel = s; db_we = w; db_cyc = 1'b1; end
      else begin ib_adr = a; ib_cyc = 1'b1; end
      while (!got && lat < 40) begin
        @(negedge clk);
        lat++;
        if (port ? (db_ack | db_err) : (ib_ack | ib_err)) begin
          got = 1'b1;
          rd  = port ? db_rdt : ib_rdt;
          e   = port ? db_err : ib_err;
        end
      end
      ib_cyc = 1'b0; db_cyc = 1'b0; db_we = 1'b0;
      chk(g, "txn_done", 32'(got), 32'd1);
    endtask

    initial begin : master
      logic [31:0] rd;
      bit e;
      int lat, n, pd, pi, t, acks;
      logic [3:0] ord;
      int at [2];
      rst = 1'b1; ib_cyc = 1'b0; db_cyc = 1'b0; db_we = 1'b0;
      ib_adr = 30'h0; db_adr = 30'h0; db_dat = 32'h0; db_sel = 4'h0;
      repeat (3) @(negedge clk);
      chk(g, "rst_db_rdt", db_rdt, 32'h0);
      chk(g, "rst_ib_rdt", ib_rdt, 32'h0);
      chk(g, "rst_db_ack", 32'(db_ack), 32'd0);
      rst = 1'b0;

      txn(1'b1, 30'd3, 32'hDEADBEEF, 4'hF, 1'b1, rd, e, lat);
      txn(1'b0, 30'd3, 32'h0, 4'h0, 1'b0, rd, e, lat);
      chk(g, "ib_read3", rd, 32'hDEADBEEF);
      chk(g, "ib_latency", 32'(lat), 32'(LAT));

      txn(1'b1, 30'd5, 32'h11223344, 4'hF, 1'b1, rd, e, lat);
      txn(1'b1, 30'd5, 32'hAABBCCDD, 4'b0101, 1'b1, rd, e, lat);
      chk(g, "lane_prewrite", rd, 32'h11223344);
      txn(1'b1, 30'd5, 32'h0, 4'h0, 1'b0, rd, e, lat);
      chk(g, "lane_merge", rd, 32'h11BB33DD);

      // Reset one cycle after the grant edge of a write.
      @(negedge clk);
      db_adr = 30'd2; db_dat = 32'h5A5A5A5A; db_sel = 4'hF; db_we = 1'b1; db_cyc = 1'b1;
      @(negedge clk);
      acks = int'(db_ack);
      rst = 1'b1;
      @(negedge clk);
      acks += int'(db_ack);
      chk(g, "rst_mid_ack", 32'(db_ack), 32'd0);
      chk(g, "rst_mid_rdt", db_rdt, 32'h0);
      rst = 1'b0; db_cyc = 1'b0; db_we = 1'b0;
      chk(g, "rst_mid_acks", 32'(acks), (LAT == 1) ? 32'd1 : 32'd0);
      txn(1'b1, 30'd2, 32'h0, 4'h0, 1'b0, rd, e, lat);
      chk(g, "rst_mid_kept", rd, 32'h5A5A5A5A);

      // Both ports hold cyc for two transfers each.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ib_adr = 30'd3; db_adr = 30'd5; db_we = 1'b0;
      ib_cyc = 1'b1; db_cyc = 1'b1; pd = 2; pi = 2; n = 0; ord = 4'h0;
      for (int k = 0; k < 80 && n < 4; k++) begin
        @(negedge clk);
        if (db_ack) begin
          ord = {ord[2:0], 1'b1}; n++; pd--;
          if (pd == 0) db_cyc = 1'b0;
        end else if (ib_ack) begin
          ord = {ord[2:0], 1'b0}; n++; pi--;
          if (pi == 0) ib_cyc = 1'b0;
        end
      end
      ib_cyc = 1'b0; db_cyc = 1'b0;
      chk(g, "arb_count", 32'(n), 32'd4);
      chk(g, "arb_order", 32'(ord), (RR == 1) ? 32'hA : 32'hC);

      // Back-to-back reads with cyc held.
      @(negedge clk);
      db_adr = 30'd3; db_we = 1'b0; db_cyc = 1'b1; t = 0; n = 0; at[0] = 0; at[1] = 0;
      for (int k = 0; k < 40 && n < 2; k++) begin
        @(negedge clk);
        t++;
        if (db_ack) begin at[n] = t; n++; end
      end
      db_cyc = 1'b0;
      chk(g, "b2b_first", 32'(at[0]), 32'(LAT));
      chk(g, "b2b_period", 32'(at[1] - at[0]), 32'(LAT + 1));

      // Byte address 0x100 is past depth: error or wrap to word 0.
      txn(1'b1, 30'd0, 32'hCAFEF00D, 4'hF, 1'b1, rd, e, lat);
      txn(1'b1, 30'h40, 32'h12345678, 4'hF, 1'b1, rd, e, lat);
      chk(g, "oor_err", 32'(e), 32'(ERR_ON));
      txn(1'b1, 30'd0, 32'h0, 4'h0, 1'b0, rd, e, lat);
      chk(g, "oor_word0", rd, ERR_ON ? 32'hCAFEF00D : 32'h12345678);

      // Requester drops cyc right after the grant edge.
      @(negedge clk);
      db_adr = 30'd7; db_dat = 32'h0BADF00D; db_sel = 4'hF; db_we = 1'b1; db_cyc = 1'b1;
      @(negedge clk);
      acks = int'(db_ack);
      db_cyc = 1'b0; db_we = 1'b0;
      repeat (LAT + 2) begin
        @(negedge clk);
        acks += int'(db_ack);
      end
      chk(g, "drop_acks", 32'(acks), (LAT == 1) ? 32'd1 : 32'd0);
      txn(1'b1, 30'd7, 32'h0, 4'h0, 1'b0, rd, e, lat);
      chk(g, "drop_kept", rd, 32'h0BADF00D);

      // Random traffic on both ports, occasionally abandoning a request.
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (ib_cyc && (ib_ack || ib_err)) ib_cyc = 1'b0;
        else if (ib_cyc && $urandom_range(0, 31) == 0) ib_cyc = 1'b0;
        else if (!ib_cyc && $urandom_range(0, 2) == 0) begin
          ib_adr = rnd_adr(); ib_cyc = 1'b1;
        end
        if (db_cyc && (db_ack || db_err)) begin db_cyc = 1'b0; db_we = 1'b0; end
        else if (db_cyc && $urandom_range(0, 31) == 0) begin db_cyc = 1'b0; db_we = 1'b0; end
        else if (!db_cyc && $urandom_range(0, 2) == 0) begin
          db_adr = rnd_adr(); db_dat = $urandom(); db_sel = 4'($urandom_range(0, 15));
          db_we = 1'($urandom_range(0, 1)); db_cyc = 1'b1;
        end
      end
      ib_cyc = 1'b0; db_cyc = 1'b0; db_we = 1'b0;
      repeat (10) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
